// File: rtl/ntt_layer_sequencer.sv
// ntt_layer_sequencer
// Runs one NTT/INTT layer over a 256-coefficient Kyber polynomial.
// Each cycle it issues one coefficient pair (j, j+len) to a dual-read RAM.
// One cycle later the RAM data goes to the butterfly. The butterfly results
// are written back in place, using an address tag FIFO that does not depend
// on the butterfly latency.
//
// Ports
//   clk, r                 clock, asynchronous active-low reset
//   start, log_len, inverse  layer request (log_len = k, len = 2^k)
//   rd_en, rd_addr_a/b     RAM read request (data returns 1 cycle later)
//   rd_data_a/b            RAM read data
//   bf_in_1/2, bf_valid_in butterfly operands and strobe
//   bf_inverse, grp_idx    butterfly mode and twiddle group of the pair
//   bf_valid_out, bf_u/v   butterfly results
//   wr_en, wr_addr_a/b, wr_data_a/b  RAM write-back
//   busy, done, err        status (err is sticky until reset)
module ntt_layer_sequencer #(
    parameter int N       = 256,
    parameter int AW      = 8,
    parameter int TAG_DEP = 8
) (
    input  logic          clk,
    input  logic          r,
    input  logic          start,
    input  logic [2:0]    log_len,
    input  logic          inverse,
    output logic [AW-1:0] rd_addr_a,
    output logic [AW-1:0] rd_addr_b,
    output logic          rd_en,
    input  logic [11:0]   rd_data_a,
    input  logic [11:0]   rd_data_b,
    output logic [11:0]   bf_in_1,
    output logic [11:0]   bf_in_2,
    output logic          bf_valid_in,
    output logic          bf_inverse,
    output logic [6:0]    grp_idx,
    input  logic          bf_valid_out,
    input  logic [11:0]   bf_u,
    input  logic [11:0]   bf_v,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr_a,
    output logic [AW-1:0] wr_addr_b,
    output logic [11:0]   wr_data_a,
    output logic [11:0]   wr_data_b,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int PW  = AW - 1;
    localparam int PTW = $clog2(TAG_DEP);
    localparam int CW  = $clog2(TAG_DEP + 1);
    localparam logic [PW-1:0] LAST_P = PW'(N / 2 - 1);
    localparam logic [CW-1:0] FULL   = CW'(TAG_DEP);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_p;
    logic [2:0]      r_k;
    logic            r_inv;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr_a;
    logic [AW-1:0]   r_rd_addr_b;
    logic [6:0]      r_rd_grp;
    logic            r_valid_in;
    logic [6:0]      r_grp_out;
    logic            r_busy;
    logic            r_done;
    logic            r_err;
    logic [2*AW-1:0] r_tags [TAG_DEP];
    logic [PTW-1:0]  r_wptr;
    logic [PTW-1:0]  r_rptr;
    logic [CW-1:0]   r_count;

    logic [AW-1:0]   w_p_ext;
    logic [AW-1:0]   w_len;
    logic [AW-1:0]   w_grp;
    logic [AW-1:0]   w_j;
    logic [AW-1:0]   w_jb;
    logic            w_pop;
    logic            w_room;
    logic            w_issue;
    logic [2*AW-1:0] w_head;

    // Pair p maps to j = (group << (k+1)) | offset-in-group. The partner is j+len.
    assign w_p_ext = {1'b0, r_p};
    assign w_len   = AW'(1) << r_k;
    assign w_grp   = w_p_ext >> r_k;
    assign w_j     = (w_grp << ({1'b0, r_k} + 4'd1)) | (w_p_ext & (w_len - AW'(1)));
    assign w_jb    = w_j + w_len;

    // A pop that happens on the same edge frees a slot. This lets the FIFO stay
    // full at steady state without stalling the issue.
    assign w_pop   = bf_valid_out && (r_count != '0);
    assign w_room  = (r_count != FULL) || w_pop;
    assign w_issue = (r_state == S_ISSUE) && w_room;
    assign w_head  = r_tags[r_rptr];

    // RAM data passes straight through to the butterfly. Outside a valid slot
    // the operands are zero.
    assign rd_en       = r_rd_en;
    assign rd_addr_a   = r_rd_addr_a;
    assign rd_addr_b   = r_rd_addr_b;
    assign bf_valid_in = r_valid_in;
    assign bf_in_1     = r_valid_in ? rd_data_a : '0;
    assign bf_in_2     = r_valid_in ? rd_data_b : '0;
    assign grp_idx     = r_grp_out;
    assign bf_inverse  = r_inv;

    // The write-back presents the FIFO head in the same cycle as the butterfly result.
    assign wr_en     = w_pop;
    assign wr_addr_a = w_pop ? w_head[2*AW-1:AW] : '0;
    assign wr_addr_b = w_pop ? w_head[AW-1:0] : '0;
    assign wr_data_a = w_pop ? bf_u : '0;
    assign wr_data_b = w_pop ? bf_v : '0;

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

    // Tag storage holds the in-flight write addresses. It has no reset,
    // because the pointers and the count define which slots are valid.
    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_tags[r_wptr] <= {w_j, w_jb};
        end
    end

    // The layer FSM, issue pipeline, tag FIFO bookkeeping and status flags
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            r_state     <= S_IDLE;
            r_p         <= '0;
            r_k         <= '0;
            r_inv       <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_rd_grp    <= '0;
            r_valid_in  <= 1'b0;
            r_grp_out   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
        end else begin
            r_rd_en    <= w_issue;
            r_valid_in <= r_rd_en;
            r_grp_out  <= r_rd_en ? r_rd_grp : '0;
            r_done     <= 1'b0;

            if (w_issue) begin
                r_rd_addr_a <= w_j;
                r_rd_addr_b <= w_jb;
                r_rd_grp    <= 7'(w_grp);
                r_p         <= r_p + 1'b1;
                r_wptr      <= (r_wptr == PTW'(TAG_DEP - 1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PTW'(TAG_DEP - 1)) ? '0 : r_rptr + 1'b1;
            end
            case ({w_issue, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (bf_valid_out && !w_pop) begin
                r_err <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_k     <= log_len;
                        r_inv   <= inverse;
                        r_p     <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (w_issue && (r_p == LAST_P)) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((r_count == '0) && !r_rd_en && !r_valid_in) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
